pipe_fetch: RTL and testbench
=============================

PIPE_FETCH -- requirements
Module: pipe_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000000, instruction word (sll $0,$0,0) inserted as a bubble.
REQ-003 SHALL have ports:
- clock  in  1  single clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- pcsource  in  2  next-PC select from ID: 00 = pc+4, 01 = bpc, 10 = da (jr), 11 = jpc.
- bpc  in  32  branch target from ID.
- da  in  32  forwarded rs value from ID (jr target).
- jpc  in  32  jump target from ID.
- wpcir  in  1  1 = PC and IF/ID may advance; 0 = load-use stall from ID.
- imem_addr  out  32  fetch address; always equal to pc.
- imem_req  out  1  fetch request.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- pc  out  32  current fetch PC.
- dpc4  out  32  IF/ID register: fetch PC + 4 of the instruction in ID.
- inst  out  32  IF/ID register: instruction in ID.
- dvalid  out  1  IF/ID register: 1 = inst is a real fetched instruction.

Function
REQ-004 SHALL implement a 3-state FSM: FETCH, WAIT, HOLD.
REQ-005 SHALL drive imem_req=1 in FETCH and WAIT, 0 in HOLD and while resetn=0.
REQ-006 SHALL compute npc: pending redirect target if pend_v=1, else the pcsource mux (00 = pc+4, 01 = bpc, 10 = da, 11 = jpc).
REQ-007 FETCH/WAIT, imem_ready=1, wpcir=1: SHALL load inst=imem_rdata, dpc4=pc+4, dvalid=1, pc=npc, clear pend_v, go to FETCH.
REQ-008 FETCH/WAIT, imem_ready=1, wpcir=0: SHALL capture imem_rdata and pc+4 into a hold buffer, keep pc and IF/ID, go to HOLD.
REQ-009 FETCH/WAIT, imem_ready=0, wpcir=1: SHALL load IF/ID with inst=NOP_INST, dvalid=0, dpc4 unchanged, keep pc, go to WAIT.
REQ-010 FETCH/WAIT, imem_ready=0, wpcir=0: SHALL keep pc and IF/ID unchanged, go to WAIT.
REQ-011 HOLD, wpcir=1: SHALL load IF/ID from the hold buffer with dvalid=1, set pc=npc, clear pend_v, go to FETCH.
REQ-012 HOLD, wpcir=0: SHALL keep all state unchanged.
REQ-013 Redirect capture: if wpcir=1, dvalid=1, pcsource!=00 and pc does not update this cycle, SHALL latch the selected target into pend_tgt and set pend_v=1.
REQ-014 When pend_v=1, SHALL ignore pcsource for npc; pend_v clears only on a pc update or on reset.
REQ-015 SHALL use a 32-bit adder for pc+4 and discard the carry; 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-016 SHALL NOT fetch the delay-slot instruction differently from any other instruction; squashing it is ID's job via dbubble.
REQ-017 SHALL assert imem_addr=pc combinationally and hold it stable for every cycle imem_req=1 and imem_ready=0.
REQ-018 Fetch latency: with imem_ready tied 1 and wpcir=1, the instruction at address A SHALL appear on inst exactly 1 cycle after pc=A.

Reset
REQ-019 resetn=0 at a rising edge SHALL set: pc=RESET_PC, state=FETCH, inst=NOP_INST, dpc4=0, dvalid=0, pend_v=0, pend_tgt=0, hold buffer=0.
REQ-020 Reset SHALL override every other condition, including mid-WAIT, mid-HOLD and a pending redirect; no pending redirect survives reset.
REQ-021 SHALL make no state change other than reset when resetn=0.

Verification
REQ-022 Straight-line: imem_ready=1, wpcir=1, pcsource=00, memory word = address. -> After reset, inst sequence 0x0, 0x4, 0x8 on successive cycles; dpc4 = 0x4, 0x8, 0xC; dvalid=1.
REQ-023 Load-use stall: wpcir=0 for 2 cycles while pc=0x10. -> pc holds 0x10; inst/dpc4 frozen; FSM enters HOLD; imem_req=0. When wpcir=1: inst=mem[0x10], pc=0x14.
REQ-024 Wait states: imem_ready=0 for 3 cycles at pc=0x20, wpcir=1. -> dvalid=0, inst=NOP for 3 cycles, pc=0x20 throughout. Then inst=mem[0x20], dvalid=1.
REQ-025 Redirect during wait: with dvalid=1, pcsource=01, bpc=0x100 while imem_ready=0, then pcsource=00. -> pend_v=1. On first ready, pc=0x100.
REQ-026 jr/j select: pcsource=10 with da=0x40, then pcsource=11 with jpc=0x80, imem_ready=1. -> pc takes 0x40, then 0x80, on successive advances.
REQ-027 Reset mid-HOLD with pend_v=1. -> Next cycle: pc=RESET_PC, dvalid=0, inst=NOP, pend_v=0, state=FETCH.

Source files
------------

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a small
// FETCH/WAIT/HOLD controller that absorbs memory wait states and load-use stalls.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_dpc4;
    logic        r_dvalid;
    logic        r_pend_v;
    logic [31:0] r_pend_tgt;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc4;

    logic        w_pc_upd;
    logic        w_ifid_ld;
    logic        w_use_hold;
    logic        w_hold_ld;
    logic        w_bubble;
    logic        w_capture;
    logic [31:0] w_pc4;
    logic [31:0] w_sel;
    logic [31:0] w_npc;

    // Carry out of bit 31 is dropped, so the PC wraps to zero.
    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_sel = w_pc4;
        case (pcsource)
            2'b00:   w_sel = w_pc4;
            2'b01:   w_sel = bpc;
            2'b10:   w_sel = da;
            default: w_sel = jpc;
        endcase
    end

    // A redirect seen while the PC cannot move is remembered so it is not lost
    // once ID has moved on and pcsource goes back to sequential.
    assign w_npc = r_pend_v ? r_pend_tgt : w_sel;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_pc_upd    = 1'b0;
        w_ifid_ld   = 1'b0;
        w_use_hold  = 1'b0;
        w_hold_ld   = 1'b0;
        w_bubble    = 1'b0;
        case (r_state)
            S_FETCH, S_WAIT: begin
                if (imem_ready) begin
                    if (wpcir) begin
                        w_pc_upd    = 1'b1;
                        w_ifid_ld   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_hold_ld   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_bubble    = wpcir;
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                if (wpcir) begin
                    w_pc_upd    = 1'b1;
                    w_ifid_ld   = 1'b1;
                    w_use_hold  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    assign w_capture = wpcir && r_dvalid && (pcsource != 2'b00) && !w_pc_upd;

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pc        <= RESET_PC;
            r_inst      <= NOP_INST;
            r_dpc4      <= 32'd0;
            r_dvalid    <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_tgt  <= 32'd0;
            r_hold_inst <= 32'd0;
            r_hold_pc4  <= 32'd0;
        end else begin
            if (w_pc_upd) begin
                r_pc     <= w_npc;
                r_pend_v <= 1'b0;
            end else if (w_capture) begin
                r_pend_v   <= 1'b1;
                r_pend_tgt <= w_sel;
            end

            if (w_ifid_ld) begin
                r_inst   <= w_use_hold ? r_hold_inst : imem_rdata;
                r_dpc4   <= w_use_hold ? r_hold_pc4  : w_pc4;
                r_dvalid <= 1'b1;
            end else if (w_bubble) begin
                r_inst   <= NOP_INST;
                r_dvalid <= 1'b0;
            end

            if (w_hold_ld) begin
                r_hold_inst <= imem_rdata;
                r_hold_pc4  <= w_pc4;
            end
        end
    end

    assign imem_addr = r_pc;
    assign imem_req  = resetn && (r_state != S_HOLD);
    assign pc        = r_pc;
    assign dpc4      = r_dpc4;
    assign inst      = r_inst;
    assign dvalid    = r_dvalid;

endmodule

// File: tb/tb_pipe_fetch.sv
// Bench for pipe_fetch: directed scenarios with fixed expectations, then a
// randomized run compared against a transaction-level model of the fetch stage.
module tb_pipe_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0BAD_F00D;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] da;
    logic [31:0] jpc;
    logic        wpcir;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] inst;
    logic        dvalid;

    logic [31:0] mem_key;
    int          total;
    int          bad;

    pipe_fetch #(
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .da         (da),
        .jpc        (jpc),
        .wpcir      (wpcir),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst),
        .dvalid     (dvalid)
    );

    // Instruction memory: each word is its own address, optionally scrambled.
    assign imem_rdata = imem_addr ^ mem_key;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; outputs are then looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; wpcir = 1'b1; imem_ready = 1'b1; pcsource = 2'b00;
        bpc = '0; da = '0; jpc = '0; mem_key = '0;
        tick(); tick();
        total++; if (pc !== RST_PC)     begin bad++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        total++; if (inst !== NOP)      begin bad++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
        total++; if (dpc4 !== 32'd0)    begin bad++; $display("FAIL reset_dpc4: got %h want 0", dpc4); end
        total++; if (dvalid !== 1'b0)   begin bad++; $display("FAIL reset_dvalid: got %b want 0", dvalid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req_low: got %b want 0", imem_req); end
        resetn = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req_fetch: got %b want 1", imem_req); end
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
    endtask

    task automatic test_straight_line();
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (inst !== 32'(4 * k)) begin bad++; $display("FAIL straight_inst%0d: got %h want %h", k, inst, 32'(4 * k)); end
            total++; if (dpc4 !== 32'(4 * k + 4)) begin bad++; $display("FAIL straight_dpc4%0d: got %h want %h", k, dpc4, 32'(4 * k + 4)); end
            total++; if (dvalid !== 1'b1) begin bad++; $display("FAIL straight_dvalid%0d: got %b want 1", k, dvalid); end
        end
        tick();
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL straight_pc: got %h want 10", pc); end
    endtask

    task automatic test_load_use_stall();
        wpcir = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (pc !== 32'h10)  begin bad++; $display("FAIL stall_pc%0d: got %h want 10", k, pc); end
            total++; if (inst !== 32'hC) begin bad++; $display("FAIL stall_inst%0d: got %h want c", k, inst); end
            total++; if (dpc4 !== 32'h10) begin bad++; $display("FAIL stall_dpc4%0d: got %h want 10", k, dpc4); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req%0d: got %b want 0", k, imem_req); end
        end
        wpcir = 1'b1;
        tick();
        total++; if (inst !== 32'h10) begin bad++; $display("FAIL stall_release_inst: got %h want 10", inst); end
        total++; if (dpc4 !== 32'h14) begin bad++; $display("FAIL stall_release_dpc4: got %h want 14", dpc4); end
        total++; if (pc !== 32'h14)   begin bad++; $display("FAIL stall_release_pc: got %h want 14", pc); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stall_release_req: got %b want 1", imem_req); end
    endtask

    task automatic test_wait_states();
        tick(); tick(); tick();
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL wait_setup_pc: got %h want 20", pc); end
        mem_key = 32'h5500_0000;
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (dvalid !== 1'b0) begin bad++; $display("FAIL wait_dvalid%0d: got %b want 0", k, dvalid); end
            total++; if (inst !== NOP)    begin bad++; $display("FAIL wait_inst%0d: got %h want %h", k, inst, NOP); end
            total++; if (pc !== 32'h20)   begin bad++; $display("FAIL wait_pc%0d: got %h want 20", k, pc); end
            total++; if (dpc4 !== 32'h20) begin bad++; $display("FAIL wait_dpc4%0d: got %h want 20", k, dpc4); end
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h20)
                begin bad++; $display("FAIL wait_req%0d: got req=%b addr=%h want req=1 addr=20", k, imem_req, imem_addr); end
        end
        imem_ready = 1'b1;
        tick();
        total++; if (inst !== 32'h5500_0020) begin bad++; $display("FAIL wait_done_inst: got %h want 55000020", inst); end
        total++; if (dvalid !== 1'b1) begin bad++; $display("FAIL wait_done_dvalid: got %b want 1", dvalid); end
        total++; if (pc !== 32'h24)   begin bad++; $display("FAIL wait_done_pc: got %h want 24", pc); end
        mem_key = '0;
    endtask

    task automatic test_redirect_in_wait();
        imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h100;
        tick();
        pcsource = 2'b00; bpc = 32'hDEAD_BEE0;
        tick();
        total++; if (pc !== 32'h24) begin bad++; $display("FAIL redir_wait_pc: got %h want 24", pc); end
        imem_ready = 1'b1;
        tick();
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL redir_target: got %h want 100", pc); end
        total++; if (inst !== 32'h24) begin bad++; $display("FAIL redir_inst: got %h want 24", inst); end
    endtask

    task automatic test_jr_j();
        pcsource = 2'b10; da = 32'h40;
        tick();
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL jr_pc: got %h want 40", pc); end
        pcsource = 2'b11; jpc = 32'h80;
        tick();
        total++; if (pc !== 32'h80) begin bad++; $display("FAIL j_pc: got %h want 80", pc); end
        total++; if (inst !== 32'h40) begin bad++; $display("FAIL j_inst: got %h want 40", inst); end
    endtask

    task automatic test_pc_wrap();
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        tick();
        pcsource = 2'b00;
        tick();
        total++; if (pc !== 32'h0)   begin bad++; $display("FAIL wrap_pc: got %h want 0", pc); end
        total++; if (dpc4 !== 32'h0) begin bad++; $display("FAIL wrap_dpc4: got %h want 0", dpc4); end
        total++; if (inst !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_inst: got %h want fffffffc", inst); end
    endtask

    task automatic test_reset_mid_hold();
        tick();
        imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h200;
        tick();
        pcsource = 2'b00; imem_ready = 1'b1; wpcir = 1'b0;
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rhold_in_hold: got %b want 0", imem_req); end
        resetn = 1'b0;
        tick();
        total++; if (pc !== RST_PC)   begin bad++; $display("FAIL rhold_pc: got %h want %h", pc, RST_PC); end
        total++; if (dvalid !== 1'b0) begin bad++; $display("FAIL rhold_dvalid: got %b want 0", dvalid); end
        total++; if (inst !== NOP)    begin bad++; $display("FAIL rhold_inst: got %h want %h", inst, NOP); end
        resetn = 1'b1; wpcir = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rhold_state_fetch: got %b want 1", imem_req); end
        tick();
        total++; if (pc !== RST_PC + 32'd4) begin bad++; $display("FAIL rhold_no_pending: got %h want %h", pc, RST_PC + 32'd4); end
        total++; if (inst !== RST_PC) begin bad++; $display("FAIL rhold_first_inst: got %h want %h", inst, RST_PC); end
    endtask

    // Transaction-level model: a PC, an IF/ID slot, an optional parked word
    // (fetched but refused by ID) and an optional remembered redirect.
    logic [31:0] m_pc, m_inst, m_dpc4, m_park_inst, m_park_pc4, m_redir_tgt;
    logic        m_dvalid, m_parked, m_redir;

    function automatic logic [31:0] chosen_target(logic [31:0] cur_pc);
        case (pcsource)
            2'b00:   return cur_pc + 32'd4;
            2'b01:   return bpc;
            2'b10:   return da;
            default: return jpc;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] target;
        logic        advanced;
        logic        redirect_seen;
        if (!resetn) begin
            m_pc = RST_PC; m_inst = NOP; m_dpc4 = '0; m_dvalid = 1'b0;
            m_parked = 1'b0; m_redir = 1'b0; m_redir_tgt = '0;
            m_park_inst = '0; m_park_pc4 = '0;
            return;
        end
        target        = m_redir ? m_redir_tgt : chosen_target(m_pc);
        redirect_seen = wpcir && m_dvalid && (pcsource != 2'b00);
        advanced      = 1'b0;
        if (m_parked) begin
            if (wpcir) begin
                m_inst = m_park_inst; m_dpc4 = m_park_pc4; m_dvalid = 1'b1;
                m_parked = 1'b0; advanced = 1'b1;
            end
        end else if (imem_ready) begin
            if (wpcir) begin
                m_inst = m_pc ^ mem_key; m_dpc4 = m_pc + 32'd4; m_dvalid = 1'b1;
                advanced = 1'b1;
            end else begin
                m_park_inst = m_pc ^ mem_key; m_park_pc4 = m_pc + 32'd4; m_parked = 1'b1;
            end
        end else if (wpcir) begin
            m_inst = NOP; m_dvalid = 1'b0;
        end
        if (advanced) begin
            m_pc = target; m_redir = 1'b0;
        end else if (redirect_seen) begin
            m_redir_tgt = chosen_target(m_pc); m_redir = 1'b1;
        end
    endtask

    task automatic test_random();
        mem_key = 32'hA5A5_0000;
        resetn = 1'b0;
        for (int n = 0; n < 600; n++) begin
            model_step();
            tick();
            total++;
            if (pc !== m_pc || inst !== m_inst || dpc4 !== m_dpc4 || dvalid !== m_dvalid ||
                imem_addr !== m_pc || imem_req !== (resetn && !m_parked)) begin
                bad++;
                $display("FAIL random_cycle%0d: got pc=%h inst=%h dpc4=%h dv=%b req=%b want pc=%h inst=%h dpc4=%h dv=%b req=%b",
                         n, pc, inst, dpc4, dvalid, imem_req,
                         m_pc, m_inst, m_dpc4, m_dvalid, resetn && !m_parked);
            end
            resetn     = ($urandom_range(0, 49) != 0);
            wpcir      = ($urandom_range(0, 3) != 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            pcsource   = 2'($urandom_range(0, 3));
            bpc        = $urandom() & 32'hFFFF_FFFC;
            da         = $urandom() & 32'hFFFF_FFFC;
            jpc        = $urandom() & 32'hFFFF_FFFC;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_straight_line();
        test_load_use_stall();
        test_wait_states();
        test_redirect_in_wait();
        test_jr_j();
        test_pc_wrap();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
